// File: rtl/nios2_fmeasure_poller.sv
// nios2_fmeasure_poller
// Periodically issues single-cycle Avalon-MM reads to a fixed-latency
// measurement register and queues each returned sample in a small FIFO
// that feeds the AGC datapath over a valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | polling disabled, nothing in flight
// WAIT    | counting down the inter-poll gap
// READ    | avm_read asserted for one cycle
// CAPTURE | slave data valid this cycle; push to FIFO, reload gap timer
module nios2_fmeasure_poller #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 2,
  parameter int POLL_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       period,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        overflow_cnt,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_READ    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_timer;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_ovf;

  logic w_capture;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; disabling in WAIT abandons the gap without a read
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    w_state_nxt = enable ? S_READ : S_IDLE;
      S_READ:    w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == 16'd0) begin
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    avm_read  = 1'b0;
    busy      = 1'b1;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE:    busy      = 1'b0;
      S_READ:    avm_read  = 1'b1;
      S_CAPTURE: w_capture = 1'b1;
      default:   busy      = 1'b1;
    endcase
  end

  assign avm_address = ADDR_W'(POLL_ADDR);

  // Gap timer: loaded from period on each capture, counts down in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= 16'd0;
    end else if (w_capture) begin
      r_timer <= period;
    end else if (r_state == S_WAIT && r_timer != 16'd0) begin
      r_timer <= r_timer - 16'd1;
    end
  end

  // A full FIFO still accepts the sample when a pop frees a slot this cycle
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;
  assign out_data  = r_mem[r_rd_ptr];

  // Sample storage; cleared on reset so out_data reads zero when flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= avm_readdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Dropped-sample counter, saturating at 255
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 8'd0;
    end else if (w_drop && r_ovf != 8'hFF) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_nios2_fmeasure_poller.sv
// Directed bench for nios2_fmeasure_poller with a latency-1 slave model.
module tb_nios2_fmeasure_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  overflow_cnt;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rd_n   = 0;
  int slv_cnt = 0;
  int cyc_en;
  int rd0;
  int rd_cyc[$];
  logic [31:0] pop_q[$];

  nios2_fmeasure_poller #(
    .DATA_W(32), .ADDR_W(2), .POLL_ADDR(0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow_cnt(overflow_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave returns 0x11 * n for the n-th read, valid the cycle after avm_read
  assign avm_readdata = 32'(slv_cnt) * 32'h11;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (avm_read) begin
      slv_cnt = slv_cnt + 1;
      rd_n    = rd_n + 1;
      rd_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) pop_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_reads(input int target, input int budget);
    int k;
    k = 0;
    while (rd_n < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rd_n < target) chk("read_timeout", 64'(rd_n), 64'(target));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; period = 16'd5; out_ready = 1'b1;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    chk("rst_avm_read", 64'(avm_read), 64'd0);
    chk("rst_avm_address", 64'(avm_address), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_overflow", 64'(overflow_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Test 1: period 5, three polls, pulses at relative cycles 1, 9, 17
    rd_cyc.delete(); pop_q.delete(); rd_n = 0; slv_cnt = 0;
    enable = 1'b1;
    cyc_en = cyc;
    wait_reads(3, 100);
    enable = 1'b0;
    cycles(12);
    chk("t1_reads", 64'(rd_n), 64'd3);
    if (rd_cyc.size() >= 3) begin
      chk("t1_pulse0", 64'(rd_cyc[0] - cyc_en - 1), 64'd1);
      chk("t1_pulse1", 64'(rd_cyc[1] - cyc_en - 1), 64'd9);
      chk("t1_pulse2", 64'(rd_cyc[2] - cyc_en - 1), 64'd17);
    end
    chk("t1_pops", 64'(pop_q.size()), 64'd3);
    if (pop_q.size() >= 3) begin
      chk("t1_data0", 64'(pop_q[0]), 64'h11);
      chk("t1_data1", 64'(pop_q[1]), 64'h22);
      chk("t1_data2", 64'(pop_q[2]), 64'h33);
    end
    chk("t1_overflow", 64'(overflow_cnt), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // Test 2: period 0, no drain, six polls -> four held, two dropped
    do_reset();
    pop_q.delete(); rd_n = 0; slv_cnt = 0;
    period = 16'd0; out_ready = 1'b0; enable = 1'b1;
    wait_reads(6, 100);
    enable = 1'b0;
    cycles(2);
    chk("t2_overflow", 64'(overflow_cnt), 64'd2);
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_out_data", 64'(out_data), 64'h11);

    // Test 3: full FIFO with a pop on the CAPTURE cycle -> no drop
    period = 16'd3; enable = 1'b1;
    wait_reads(7, 50);
    out_ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t3_overflow", 64'(overflow_cnt), 64'd2);
    chk("t3_head", 64'(out_data), 64'h22);
    out_ready = 1'b1;
    cycles(4);
    chk("t3_empty", 64'(out_valid), 64'd0);
    chk("t3_pops", 64'(pop_q.size()), 64'd5);
    if (pop_q.size() >= 5) begin
      chk("t3_pop0", 64'(pop_q[0]), 64'h11);
      chk("t3_pop1", 64'(pop_q[1]), 64'h22);
      chk("t3_pop2", 64'(pop_q[2]), 64'h33);
      chk("t3_pop3", 64'(pop_q[3]), 64'h44);
      chk("t3_pop4", 64'(pop_q[4]), 64'h77);
    end

    // Test 4a: enable dropped during READ -> sample still pushed, then IDLE
    pop_q.delete();
    rd0 = rd_n;
    enable = 1'b1;
    @(negedge clk);
    chk("t4a_read", 64'(avm_read), 64'd1);
    enable = 1'b0;
    cycles(5);
    chk("t4a_reads", 64'(rd_n - rd0), 64'd1);
    chk("t4a_busy", 64'(busy), 64'd0);
    chk("t4a_pops", 64'(pop_q.size()), 64'd1);
    if (pop_q.size() >= 1) chk("t4a_data", 64'(pop_q[0]), 64'h88);

    // Test 4b: enable dropped in WAIT -> IDLE next cycle, no read
    period = 16'd10; enable = 1'b1;
    rd0 = rd_n;
    wait_reads(rd0 + 1, 20);
    @(negedge clk);
    chk("t4b_busy_wait", 64'(busy), 64'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("t4b_busy_idle", 64'(busy), 64'd0);
    cycles(20);
    chk("t4b_reads", 64'(rd_n - rd0), 64'd1);

    // Test 5: 300 drops saturate overflow_cnt at 255
    do_reset();
    rd_n = 0;
    period = 16'd0; out_ready = 1'b0; enable = 1'b1;
    wait_reads(304, 2000);
    enable = 1'b0;
    cycles(3);
    chk("t5_overflow_sat", 64'(overflow_cnt), 64'd255);
    out_ready = 1'b1;
    cycles(6);
    chk("t5_drained", 64'(out_valid), 64'd0);
    chk("t5_overflow_hold", 64'(overflow_cnt), 64'd255);

    // Test 6: reset in CAPTURE with two samples buffered
    out_ready = 1'b0; period = 16'd0;
    rd0 = rd_n;
    enable = 1'b1;
    wait_reads(rd0 + 3, 50);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_avm_read", 64'(avm_read), 64'd0);
    chk("t6_overflow", 64'(overflow_cnt), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    reset = 1'b0; enable = 1'b0;
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
